shift_seq_ctrl: RTL and testbench



---
 rtl/shift_seq_ctrl_pkg.sv | 21 ++
 rtl/shift_seq_ctrl_if.sv | 23 ++
 rtl/shift_seq_ctrl_bit_tick_gen.sv | 29 ++
 rtl/shift_seq_ctrl.sv | 121 ++++++++++++
 tb/tb_shift_seq_ctrl.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/shift_seq_ctrl_pkg.sv
// Shared types and helpers for the shift_seq_ctrl frame sequencer.
// Optional build macro: SHIFT_SEQ_CTRL_PARITY_EN (used by the top, see shift_seq_ctrl.sv).
package shift_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bits needed to hold values 0..value-1, never less than one bit.
  function automatic int clog2_min1(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Producer-side handshake and serial outputs of the frame sequencer.
// master drives start/din; slave (the sequencer) drives everything else.
interface shift_seq_ctrl_if #(
  parameter int N = 4
);
  logic         start;
  logic [N-1:0] din;
  logic         ready;
  logic         s_out;
  logic         shift_en;
  logic         busy;
  logic         done;

  modport master (
    output start, din,
    input  ready, s_out, shift_en, busy, done
  );

  modport slave (
    input  start, din,
    output ready, s_out, shift_en, busy, done
  );
endinterface

// File: rtl/shift_seq_ctrl_bit_tick_gen.sv
// Bit-period prescaler: counts 0..DIV-1 and emits a tick while at DIV-1.
// clear holds the count at zero so the first period after a load is a full one.
module bit_tick_gen
  import shift_seq_ctrl_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);
  localparam int W = clog2_min1(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] r_div_cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_div_cnt <= '0;
    end else if (r_div_cnt == LAST) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  assign tick = (r_div_cnt == LAST);
endmodule

// File: rtl/shift_seq_ctrl.sv
// Parallel-to-serial frame sequencer: accepts a word, shifts it out LSB first, pulses done.
// Build macro SHIFT_SEQ_CTRL_PARITY_EN appends an even-parity bit to every frame.
module shift_seq_ctrl
  import shift_seq_ctrl_pkg::*;
#(
  parameter int N   = 4,
  parameter int DIV = 1
) (
  input  logic                clk,
  input  logic                reset,
  shift_seq_ctrl_if.slave     bus
);
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
  localparam int FRAME = N + 1;
`else
  localparam int FRAME = N;
`endif
  localparam int BW = clog2_min1(FRAME + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(FRAME - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [FRAME-1:0]  r_shreg;
  logic [FRAME-1:0]  w_shreg_next;
  logic [FRAME-1:0]  w_shreg_shifted;
  logic [FRAME-1:0]  w_load_word;
  logic [BW-1:0]     r_bit_cnt;
  logic [BW-1:0]     w_bit_cnt_next;
  logic              w_tick;
  logic              w_clear;
  logic              w_ready;
  logic              w_s_out;
  logic              w_shift_en;
  logic              w_busy;
  logic              w_done;

  // The parity bit rides in the top of the register so it leaves last.
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
  assign w_load_word = {^bus.din, bus.din};
`else
  assign w_load_word = bus.din;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < FRAME - 1; gi++) begin : g_shift
      assign w_shreg_shifted[gi] = r_shreg[gi + 1];
    end
  endgenerate
  assign w_shreg_shifted[FRAME-1] = 1'b0;

  bit_tick_gen #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (w_clear),
    .tick  (w_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_shreg   <= w_shreg_next;
      r_bit_cnt <= w_bit_cnt_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_shreg_next   = r_shreg;
    w_bit_cnt_next = r_bit_cnt;
    w_clear        = 1'b1;
    w_ready        = 1'b0;
    w_s_out        = 1'b0;
    w_shift_en     = 1'b0;
    w_busy         = 1'b0;
    w_done         = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (bus.start) begin
          w_state_next   = SHIFT;
          w_shreg_next   = w_load_word;
          w_bit_cnt_next = '0;
        end
      end
      SHIFT: begin
        w_busy  = 1'b1;
        w_clear = 1'b0;
        w_s_out = r_shreg[0];
        if (w_tick) begin
          w_shift_en = 1'b1;
          // Last bit period ends the frame rather than shifting once more.
          if (r_bit_cnt == LAST_BIT) begin
            w_state_next = DONE;
          end else begin
            w_shreg_next   = w_shreg_shifted;
            w_bit_cnt_next = r_bit_cnt + 1'b1;
          end
        end
      end
      DONE: begin
        w_busy       = 1'b1;
        w_done       = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign bus.ready    = w_ready;
  assign bus.s_out    = w_s_out;
  assign bus.shift_en = w_shift_en;
  assign bus.busy     = w_busy;
  assign bus.done     = w_done;
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: two instances (DIV=1, DIV=3) driven by the same stimulus,
// checked every cycle against a frame-timeline model plus literal expectations.
module tb_shift_seq_ctrl;
  localparam int N = 4;
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
  localparam int FRAME = N + 1;
`else
  localparam int FRAME = N;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [N-1:0] din;
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  shift_seq_ctrl_if #(.N(N)) bus1 ();
  shift_seq_ctrl_if #(.N(N)) bus3 ();
  assign bus1.start = start;
  assign bus1.din   = din;
  assign bus3.start = start;
  assign bus3.din   = din;

  shift_seq_ctrl #(.N(N), .DIV(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  shift_seq_ctrl #(.N(N), .DIV(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

  // {ready, busy, done, shift_en, s_out}
  logic [4:0] act [2];
  assign act[0] = {bus1.ready, bus1.busy, bus1.done, bus1.shift_en, bus1.s_out};
  assign act[1] = {bus3.ready, bus3.busy, bus3.done, bus3.shift_en, bus3.s_out};

  function automatic int div_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // Model: a frame is a timeline of k = cycles since acceptance.
  bit           m_valid = 1'b0;
  bit           m_active [2] = '{1'b0, 1'b0};
  int           m_k [2] = '{0, 0};
  logic [N-1:0] m_word [2];

  always @(posedge clk) begin
    if (reset) m_valid <= 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_active[i] <= 1'b0;
        m_k[i]      <= 0;
      end else if (m_active[i]) begin
        if (m_k[i] == FRAME * div_of(i) + 1) m_active[i] <= 1'b0;
        else m_k[i] <= m_k[i] + 1;
      end else if (start) begin
        m_active[i] <= 1'b1;
        m_k[i]      <= 1;
        m_word[i]   <= din;
      end
    end
  end

  function automatic logic [4:0] expect_out(input bit active, input int k,
                                            input logic [N-1:0] word, input int d);
    logic [FRAME-1:0] fb;
    fb[N-1:0] = word;
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
    fb[N] = ^word;
`endif
    if (!active) return 5'b10000;
    if (k == FRAME * d + 1) return 5'b01100;
    return {1'b0, 1'b1, 1'b0, ((k % d) == 0), fb[(k - 1) / d]};
  endfunction

  always @(negedge clk) begin
    if (m_valid) begin
      for (int i = 0; i < 2; i++) begin
        logic [4:0] e;
        e = expect_out(m_active[i], m_k[i], m_word[i], div_of(i));
        checks++;
        if (act[i] !== e) begin
          errors++;
          $display("FAIL model_div%0d at %0t: rdy/busy/done/sen/sout got %b expected %b",
                   div_of(i), $time, act[i], e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 200; n++) begin
      if (bus1.ready && bus3.ready) break;
      step();
    end
    chk("wait_idle", {30'd0, bus1.ready, bus3.ready}, 32'd3);
  endtask

  initial begin
    logic [1:12] sout_tbl;
    sout_tbl = 12'b000111111000;
    reset = 1'b1;
    start = 1'b0;
    din   = '0;
    repeat (3) step();
    reset = 1'b0;
    chk("reset_ready", bus1.ready, 1);
    chk("reset_busy", bus1.busy, 0);
    chk("reset_sout", bus1.s_out, 0);
    chk("reset_done", bus1.done, 0);
    chk("reset_shift_en", bus3.shift_en, 0);
    $display("txn reset: ready=%0b busy=%0b", bus1.ready, bus1.busy);

    // Frame 1011, DIV=1 literal timeline
    step(); din = 4'b1011; start = 1'b1;
    step(); start = 1'b0; din = '0;
    chk("t1_ready_drop", bus1.ready, 0);
`ifndef SHIFT_SEQ_CTRL_PARITY_EN
    chk("t1_sout_c1", bus1.s_out, 1);
    step(); chk("t1_sout_c2", bus1.s_out, 1);
    step(); chk("t1_sout_c3", bus1.s_out, 0);
    step(); chk("t1_sout_c4", bus1.s_out, 1);
    step(); chk("t1_done_c5", bus1.done, 1);
    step(); chk("t1_ready_c6", bus1.ready, 1);
`endif
    $display("txn frame din=1011");
    wait_idle();

    // Frame 0110, DIV=3 literal timeline
    step(); din = 4'b0110; start = 1'b1;
    step(); start = 1'b0;
`ifndef SHIFT_SEQ_CTRL_PARITY_EN
    for (int c = 1; c <= 13; c++) begin
      if (c > 1) step();
      chk($sformatf("t2_sout_c%0d", c), bus3.s_out, (c <= 12) ? sout_tbl[c] : 1'b0);
      chk($sformatf("t2_shift_en_c%0d", c), bus3.shift_en, ((c % 3) == 0 && c <= 12));
      chk($sformatf("t2_done_c%0d", c), bus3.done, (c == 13));
    end
`endif
    $display("txn frame din=0110");
    wait_idle();

    // start held high with din changing every cycle
    for (int n = 0; n < 40; n++) begin
      step();
      start = 1'b1;
      din = 4'(n * 5 + 3);
    end
    step(); start = 1'b0;
    $display("txn held start, 40 cycles");
    wait_idle();

    // Reset in cycle 2 of a DIV=1 frame aborts with no done pulse
    step(); din = 4'b1011; start = 1'b1;
    step(); start = 1'b0;
    step(); reset = 1'b1;
    step(); reset = 1'b0;
    chk("t4_ready", bus1.ready, 1);
    chk("t4_busy", bus1.busy, 0);
    chk("t4_sout", bus1.s_out, 0);
    for (int c = 0; c < 6; c++) begin
      step();
      chk("t4_no_done", bus1.done, 0);
    end
    step(); din = 4'b0101; start = 1'b1;
    step(); start = 1'b0;
    chk("t4_restart_busy", bus1.busy, 1);
    chk("t4_restart_sout", bus1.s_out, 1);
    $display("txn mid-frame reset and restart");
    wait_idle();

    // Reset wins over start
    step(); reset = 1'b1; start = 1'b1; din = 4'b1111;
    step(); reset = 1'b0; start = 1'b0;
    chk("t5_ready", bus1.ready, 1);
    chk("t5_busy", bus1.busy, 0);
    step();
    chk("t5_still_idle", bus3.busy, 0);
    $display("txn reset with start");

`ifdef SHIFT_SEQ_CTRL_PARITY_EN
    step(); din = 4'b0111; start = 1'b1;
    step(); start = 1'b0;
    chk("p_sout_c1", bus1.s_out, 1);
    step(); chk("p_sout_c2", bus1.s_out, 1);
    step(); chk("p_sout_c3", bus1.s_out, 1);
    step(); chk("p_sout_c4", bus1.s_out, 0);
    step(); chk("p_sout_c5", bus1.s_out, 1);
    step(); chk("p_done_c6", bus1.done, 1);
    $display("txn parity frame din=0111");
    wait_idle();
`endif

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
